i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

Serializer for the playback path: accepts filtered signed 16-bit stereo sample pairs from the filter chain and shifts them out MSB-first on the codec DAC data line in I2S format. It is framed by the system-clock-domain LRCLK/BCLK edge strobes already used by the filter blocks. The block sits between the last filter stage and the codec DACDAT pin. Each LRCLK period it carries one coherent left/right pair, and it reports underruns when upstream fails to deliver.

## Interface
- No parameters; word width fixed at 16 bits.
- clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- lrclk_negedge  input  1  one-clk strobe: LRCLK fell, left-channel slot begins.
- lrclk_posedge  input  1  one-clk strobe: LRCLK rose, right-channel slot begins.
- bclk_negedge  input  1  one-clk strobe: BCLK fell, DAC data may change.
- i_valid  input  1  one-clk strobe: audio_l/audio_r hold a new sample pair.
- audio_l  input  16  signed left sample, two's complement.
- audio_r  input  16  signed right sample, two's complement.
- o_sample_req  output  1  one-clk pulse on each lrclk_negedge: frame consumed, next pair requested.
- o_underrun  output  1  one-clk pulse: frame started with no fresh pair, last pair repeated.
- o_dacdat  output  1  serial DAC data to codec.

## Operation
- Pending register {pend_l, pend_r} plus a fresh flag. On i_valid, capture audio_l/audio_r into the pending register and set fresh. A second i_valid before the next frame overwrites the first; the newest pair wins and no flag is raised.
- On lrclk_negedge, copy the pending pair into the frame register {frm_l, frm_r} and clear fresh.
  - If fresh was 0, the frame register keeps its previous contents and o_underrun pulses.
  - After reset the frame register holds 0, so an early underrun transmits silence.
- Simultaneous i_valid and lrclk_negedge: the frame loads the pending contents present before this cycle. The new pair is written to pending with fresh set and serves the next frame. If fresh was 0 before this cycle, o_underrun still pulses.
- Channel word: lrclk_negedge loads the 16-bit shift register with frm_l, using the value being loaded this cycle. lrclk_posedge loads it with frm_r. L and R therefore always come from the same frame.
- FSM states:
  - IDLE: o_dacdat=0.
  - DELAY: one-BCLK I2S delay.
  - SHIFT: bit counter runs 15 down to 0.
  - PAD: o_dacdat=0 until the next LRCLK edge.
- FSM transitions:
  - Any state → DELAY on an LRCLK strobe, loading the word and resetting the counter to 15. A strobe during SHIFT aborts the current word; the new word restarts cleanly.
  - DELAY → SHIFT on the next bclk_negedge: drive bit 15.
  - SHIFT: each bclk_negedge drives the next lower bit. After bit 0 has been driven, the following bclk_negedge → PAD and drives 0.
- An LRCLK strobe and bclk_negedge in the same cycle (the normal I2S alignment): the LRCLK event wins, the state becomes DELAY, and o_dacdat keeps its current value for that cycle. That bclk_negedge is consumed as the start of the delay slot.
- bclk_negedge in IDLE or PAD: o_dacdat=0, no state change.
- No arithmetic. Samples pass bit-exact; no rounding, saturation or sign change.

## Timing
- Reset (i_rst_n=0 at a rising clk edge), all of the following on the next edge:
  - o_dacdat=0, o_sample_req=0, o_underrun=0.
  - FSM=IDLE, fresh=0, pending=0, frame=0, shift register=0, counter=15.
- Reset mid-word aborts transmission immediately. The next word starts only at a subsequent LRCLK strobe.
- o_dacdat is registered. It changes on the clk edge that samples bclk_negedge=1, so it is visible one clk after the strobe. The codec samples it at the following BCLK rising edge.
- Word latency: bit 15 appears on the second bclk_negedge after the LRCLK strobe, counting the coincident one. Bit 0 appears on the 17th.
- Sample latency: a pair accepted before lrclk_negedge N is on the wire in frame N. A pair accepted in the same cycle as strobe N goes out in frame N+1.
- o_sample_req and o_underrun are registered pulses, asserted the clk after lrclk_negedge, exactly one clk wide.
- Every LRCLK half-period needs at least 17 bclk_negedge strobes; extra strobes are padded with 0.

## Test plan
- Reset: hold i_rst_n=0 for 3 clks while toggling all strobes → o_dacdat, o_sample_req and o_underrun stay 0. After release, the first frame without i_valid → o_underrun pulse, and 32 zero bits are shifted.
- Basic frame: i_valid with L=16'hA5C3, R=16'h7001, then lrclk_negedge+bclk_negedge together, 31 further bclk_negedges, lrclk_posedge, 32 more → left slot: one delay bit, then 1010010111000011, then zeros. Right slot: one delay bit, then 0111000000000001, then zeros. o_sample_req pulses once, no underrun.
- Underrun repeat: send one pair (L=16'h8000, R=16'hFFFF), run two frames with no further i_valid → the second frame repeats 8000/FFFF and o_underrun pulses at the second lrclk_negedge only.
- Overwrite and collision: i_valid 16'h1111/2222 then 16'h3333/4444 before the frame → the frame transmits 3333/4444. Then i_valid 16'h5555/6666 coincident with lrclk_negedge → this frame repeats 3333/4444 with o_underrun=1, and the next frame transmits 5555/6666.
- Short slot abort: lrclk_posedge after only 8 bclk_negedges of the left word → left transmission stops after 7 bits, and the right word starts with a full delay bit and all 16 bits intact.
- Mid-word reset: assert i_rst_n=0 for 1 clk during bit 9 of the left word → o_dacdat=0 on the next edge and stays 0 through the remaining strobes. Output resumes correctly from the next lrclk_negedge.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S DAC serializer: double-buffers one signed 16-bit stereo pair per LRCLK frame
// and shifts it MSB-first on DACDAT, framed by system-clock LRCLK/BCLK edge strobes.
//
// state | meaning
// IDLE  | no word since reset, DACDAT held low
// DELAY | one-BCLK I2S delay slot after an LRCLK edge
// SHIFT | driving word bits, counter tracks the remaining bits
// PAD   | word done, DACDAT low until the next LRCLK edge
module i2s_dac_tx (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        lrclk_negedge,
  input  logic        lrclk_posedge,
  input  logic        bclk_negedge,
  input  logic        i_valid,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  output logic        o_sample_req,
  output logic        o_underrun,
  output logic        o_dacdat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_l_q, pend_r_q;
  logic [15:0] frm_l_q, frm_r_q, frm_l_d, frm_r_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fresh_q;
  logic        dacdat_d;

  // Frame register only advances when a fresh pair is waiting; otherwise the last pair repeats.
  always_comb begin
    frm_l_d = frm_l_q;
    frm_r_d = frm_r_q;
    if (lrclk_negedge && fresh_q) begin
      frm_l_d = pend_l_q;
      frm_r_d = pend_r_q;
    end
  end

  // An LRCLK strobe outranks a coincident bclk_negedge and holds DACDAT for that cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    dacdat_d = o_dacdat;
    if (lrclk_negedge) begin
      state_d = ST_DELAY;
      cnt_d   = 4'd15;
      shreg_d = frm_l_d;
    end else if (lrclk_posedge) begin
      state_d = ST_DELAY;
      cnt_d   = 4'd15;
      shreg_d = frm_r_q;
    end else if (bclk_negedge) begin
      case (state_q)
        ST_DELAY: begin
          dacdat_d = shreg_q[15];
          shreg_d  = {shreg_q[14:0], 1'b0};
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_q == 4'd0) begin
            dacdat_d = 1'b0;
            state_d  = ST_PAD;
          end else begin
            dacdat_d = shreg_q[15];
            shreg_d  = {shreg_q[14:0], 1'b0};
            cnt_d    = cnt_q - 4'd1;
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd15;
      shreg_q      <= '0;
      pend_l_q     <= '0;
      pend_r_q     <= '0;
      frm_l_q      <= '0;
      frm_r_q      <= '0;
      fresh_q      <= 1'b0;
      o_dacdat     <= 1'b0;
      o_sample_req <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      frm_l_q      <= frm_l_d;
      frm_r_q      <= frm_r_d;
      o_dacdat     <= dacdat_d;
      o_sample_req <= lrclk_negedge;
      o_underrun   <= lrclk_negedge & ~fresh_q;
      // A pair arriving with the frame strobe is kept for the following frame.
      if (i_valid) begin
        pend_l_q <= audio_l;
        pend_r_q <= audio_r;
        fresh_q  <= 1'b1;
      end else if (lrclk_negedge) begin
        fresh_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: stimulus pushes expected DACDAT bits and frame
// events into queues; a monitor pops and compares one clk after each strobe.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrn = 1'b0, lrp = 1'b0, bclk = 1'b0, vld = 1'b0;
  logic [15:0] al = '0, ar = '0;
  logic        o_sample_req, o_underrun, o_dacdat;

  int checks = 0;
  int errors = 0;

  logic exp_bit_q[$];
  logic exp_ur_q[$];
  logic bclk_seen = 1'b0, lrn_seen = 1'b0, rst_seen = 1'b1;
  logic line_bit = 1'b0;

  always #5 clk = ~clk;

  i2s_dac_tx dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .lrclk_negedge (lrn),
    .lrclk_posedge (lrp),
    .bclk_negedge  (bclk),
    .i_valid       (vld),
    .audio_l       (al),
    .audio_r       (ar),
    .o_sample_req  (o_sample_req),
    .o_underrun    (o_underrun),
    .o_dacdat      (o_dacdat)
  );

  always @(posedge clk) begin
    bclk_seen = bclk;
    lrn_seen  = lrn;
    rst_seen  = !rst_n;
  end

  always @(negedge clk) begin
    logic e;
    if (rst_seen) begin
      checks++;
      if (o_dacdat !== 1'b0 || o_sample_req !== 1'b0 || o_underrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: dacdat=%b req=%b ur=%b, required all 0",
                 o_dacdat, o_sample_req, o_underrun);
      end
    end else begin
      if (bclk_seen) begin
        checks++;
        if (exp_bit_q.size() == 0) begin
          errors++;
          $display("FAIL dacdat_queue: got bit %b with no expected entry", o_dacdat);
        end else begin
          e = exp_bit_q.pop_front();
          if (o_dacdat !== e) begin
            errors++;
            $display("FAIL dacdat_bit @%0t: got %b, required %b", $time, o_dacdat, e);
          end
        end
      end
      checks++;
      if (lrn_seen) begin
        if (exp_ur_q.size() == 0) begin
          errors++;
          $display("FAIL frame_queue: frame event with no expected entry");
        end else begin
          e = exp_ur_q.pop_front();
          if (o_sample_req !== 1'b1 || o_underrun !== e) begin
            errors++;
            $display("FAIL frame_event @%0t: req=%b ur=%b, required req=1 ur=%b",
                     $time, o_sample_req, o_underrun, e);
          end
        end
      end else if (o_sample_req !== 1'b0 || o_underrun !== 1'b0) begin
        errors++;
        $display("FAIL stray_pulse @%0t: req=%b ur=%b, required 0 0",
                 $time, o_sample_req, o_underrun);
      end
    end
  end

  task automatic drive(input logic r, input logic ln, input logic lp, input logic b,
                       input logic v, input logic [15:0] l, input logic [15:0] rr);
    rst_n = r; lrn = ln; lrp = lp; bclk = b; vld = v; al = l; ar = rr;
    @(negedge clk);
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, l, r);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // One LRCLK half-period: the strobe coincides with the first BCLK strobe.
  task automatic slot(input bit neg, input logic [15:0] word, input int nbclk,
                      input logic ur, input bit v, input logic [15:0] vl,
                      input logic [15:0] vr, input int rst_at);
    logic e;
    bit   killed;
    killed = 1'b0;
    for (int i = 0; i < nbclk; i++) begin
      if (i == rst_at) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        killed   = 1'b1;
        line_bit = 1'b0;
      end
      if (i == 0)            e = line_bit;
      else if (killed)       e = 1'b0;
      else if (i <= 16)      e = word[16-i];
      else                   e = 1'b0;
      exp_bit_q.push_back(e);
      line_bit = e;
      if (i == 0 && neg) exp_ur_q.push_back(ur);
      drive(1'b1, neg && i == 0, !neg && i == 0, 1'b1, v && i == 0, vl, vr);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    // Reset with all strobes toggling
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h5678);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    slot(1, 16'h0000, 32, 1'b1, 0, 16'h0, 16'h0, -1);
    slot(0, 16'h0000, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    // Basic frame
    send_pair(16'hA5C3, 16'h7001);
    slot(1, 16'hA5C3, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'h7001, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    // Underrun repeat
    send_pair(16'h8000, 16'hFFFF);
    slot(1, 16'h8000, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'hFFFF, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(1, 16'h8000, 32, 1'b1, 0, 16'h0, 16'h0, -1);
    slot(0, 16'hFFFF, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    // Overwrite and collision
    send_pair(16'h1111, 16'h2222);
    send_pair(16'h3333, 16'h4444);
    slot(1, 16'h3333, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'h4444, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(1, 16'h3333, 32, 1'b1, 1, 16'h5555, 16'h6666, -1);
    slot(0, 16'h4444, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(1, 16'h5555, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'h6666, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    // Short slot abort: only bits 15..9 of the left word go out
    send_pair(16'h9E3A, 16'hC3A5);
    slot(1, 16'h9E3A, 8, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'hC3A5, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    // Mid-word reset after bit 9, then recovery
    send_pair(16'hBEEF, 16'h0F0F);
    slot(1, 16'hBEEF, 32, 1'b0, 0, 16'h0, 16'h0, 8);
    slot(0, 16'h0000, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    send_pair(16'h6DB6, 16'h8421);
    slot(1, 16'h6DB6, 32, 1'b0, 0, 16'h0, 16'h0, -1);
    slot(0, 16'h8421, 32, 1'b0, 0, 16'h0, 16'h0, -1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (exp_bit_q.size() != 0 || exp_ur_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d bits and %0d frame events left, required 0 0",
               exp_bit_q.size(), exp_ur_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
